reward_scheduler: RTL and testbench

//  Sequences the on-screen reward for reward_display: waits a spawn delay, places one

---
 rtl/reward_pkg.sv | 43 ++++
 rtl/reward_lfsr.sv | 24 ++
 rtl/reward_scheduler.sv | 140 ++++++++++++++
 tb/tb_reward_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reward_pkg.sv
// Shared reward type codes, scheduler state encoding and the LFSR-to-grid-cell helper
// used by reward_scheduler, reward_display and the game logic.
package reward_pkg;

  localparam logic [2:0] REW_PROTECT = 3'd1;
  localparam logic [2:0] REW_FASTER  = 3'd2;
  localparam logic [2:0] REW_FROZEN  = 3'd3;
  localparam logic [2:0] REW_LASER   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SPAWN  = 3'd2,
    SHOW   = 3'd3,
    EFFECT = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] kind;
  } reward_cell_t;

  function automatic logic [4:0] fold_grid(input logic [4:0] v, input logic [4:0] grid_max);
    logic [4:0] r;
    if (v > grid_max) begin
      r = v - (grid_max + 5'd1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // A 5-bit field exceeds grid_max by at most 16, so one subtraction lands it on the grid.
  function automatic reward_cell_t derive_cell(input logic [15:0] raw, input logic [4:0] grid_max);
    reward_cell_t c;
    c.kind = {1'b0, raw[1:0]} + 3'd1;
    c.x    = fold_grid(raw[6:2], grid_max);
    c.y    = fold_grid(raw[11:7], grid_max);
    return c;
  endfunction

endpackage

// File: rtl/reward_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); a nonzero seed keeps it
// off the all-zero lock-up state forever.
module reward_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  logic feedback_s;

  assign feedback_s = value[15] ^ value[13] ^ value[12] ^ value[10];

  // shift register, advancing on every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else begin
      value <= {value[14:0], feedback_s};
    end
  end

endmodule

// File: rtl/reward_scheduler.sv
// Spawns one pseudo-random reward after a delay, shows it until pickup or expiry, and
// times the power-up effect that a pickup grants.
module reward_scheduler
  import reward_pkg::*;
#(
  parameter int unsigned SPAWN_DELAY = 8,
  parameter int unsigned SHOW_TIME   = 10,
  parameter int unsigned EFFECT_TIME = 5,
  parameter int unsigned GRID_MAX    = 23,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       game_en,
  input  logic [4:0] tank_xpos,
  input  logic [4:0] tank_ypos,
  output logic       set_require,
  output logic       enable_reward,
  output logic [4:0] random_xpos,
  output logic [4:0] random_ypos,
  output logic [2:0] reward_type,
  output logic       effect_valid,
  output logic [2:0] effect_type,
  output logic       effect_active
);

  localparam logic [7:0] SPAWN_LAST  = 8'(SPAWN_DELAY - 1);
  localparam logic [7:0] SHOW_LAST   = 8'(SHOW_TIME - 1);
  localparam logic [7:0] EFFECT_LAST = 8'(EFFECT_TIME - 1);
  localparam logic [4:0] GRID_LIMIT  = 5'(GRID_MAX);

  sched_state_e state_r;
  logic [7:0]   cnt_r;
  logic [15:0]  lfsr_s;
  reward_cell_t sample_s;
  logic         spawn_blocked_s;
  logic         pickup_s;

  reward_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr_s)
  );

  assign sample_s        = derive_cell(lfsr_s, GRID_LIMIT);
  assign spawn_blocked_s = (sample_s.x == tank_xpos) && (sample_s.y == tank_ypos);
  assign pickup_s        = (random_xpos == tank_xpos) && (random_ypos == tank_ypos);

  // scheduler FSM with its tick counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= 8'd0;
      set_require   <= 1'b0;
      enable_reward <= 1'b0;
      random_xpos   <= 5'd0;
      random_ypos   <= 5'd0;
      reward_type   <= 3'd0;
      effect_valid  <= 1'b0;
      effect_type   <= 3'd0;
      effect_active <= 1'b0;
    end else begin
      enable_reward <= game_en;
      effect_valid  <= 1'b0;
      if (!game_en) begin
        state_r       <= IDLE;
        cnt_r         <= 8'd0;
        set_require   <= 1'b0;
        effect_active <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= WAIT;
            cnt_r   <= 8'd0;
          end
          WAIT: begin
            if (tick) begin
              if (cnt_r == SPAWN_LAST) begin
                state_r <= SPAWN;
                cnt_r   <= 8'd0;
              end else begin
                cnt_r <= cnt_r + 8'd1;
              end
            end
          end
          SPAWN: begin
            // never drop a reward under the tank; the LFSR offers a new cell next cycle
            if (!spawn_blocked_s) begin
              random_xpos <= sample_s.x;
              random_ypos <= sample_s.y;
              reward_type <= sample_s.kind;
              set_require <= 1'b1;
              cnt_r       <= 8'd0;
              state_r     <= SHOW;
            end
          end
          SHOW: begin
            if (pickup_s) begin
              set_require   <= 1'b0;
              effect_valid  <= 1'b1;
              effect_type   <= reward_type;
              effect_active <= 1'b1;
              cnt_r         <= 8'd0;
              state_r       <= EFFECT;
            end else if (tick) begin
              if (cnt_r == SHOW_LAST) begin
                set_require <= 1'b0;
                cnt_r       <= 8'd0;
                state_r     <= WAIT;
              end else begin
                cnt_r <= cnt_r + 8'd1;
              end
            end
          end
          EFFECT: begin
            if (tick) begin
              if (cnt_r == EFFECT_LAST) begin
                effect_active <= 1'b0;
                cnt_r         <= 8'd0;
                state_r       <= WAIT;
              end else begin
                cnt_r <= cnt_r + 8'd1;
              end
            end
          end
          default: begin
            state_r       <= IDLE;
            cnt_r         <= 8'd0;
            set_require   <= 1'b0;
            effect_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reward_scheduler.sv
// Directed and randomized bench for reward_scheduler, checked every cycle against a
// behavioural model of the reward schedule.
module tb_reward_scheduler;

  localparam int SD = 2;
  localparam int ST = 10;
  localparam int ET = 5;
  localparam int GM = 23;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int M_IDLE = 0, M_WAIT = 1, M_SPAWN = 2, M_SHOW = 3, M_EFFECT = 4;
  localparam int TANK_HOLD = 0, TANK_AWAY = 1, TANK_CHASE = 2;

  logic       clk = 1'b0;
  logic       rst_n, tick, game_en;
  logic [4:0] tank_xpos, tank_ypos;
  logic       set_require, enable_reward, effect_valid, effect_active;
  logic [4:0] random_xpos, random_ypos;
  logic [2:0] reward_type, effect_type;

  reward_scheduler #(
    .SPAWN_DELAY (SD),
    .SHOW_TIME   (ST),
    .EFFECT_TIME (ET),
    .GRID_MAX    (GM),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .game_en       (game_en),
    .tank_xpos     (tank_xpos),
    .tank_ypos     (tank_ypos),
    .set_require   (set_require),
    .enable_reward (enable_reward),
    .random_xpos   (random_xpos),
    .random_ypos   (random_ypos),
    .reward_type   (reward_type),
    .effect_valid  (effect_valid),
    .effect_type   (effect_type),
    .effect_active (effect_active)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int tank_mode = TANK_HOLD;
  int period = 4;
  int tick_cnt = 0;
  int ticks, pulses;

  // reference model of the schedule
  logic [15:0] m_lfsr;
  int          m_phase, m_cnt;
  logic        m_set, m_ev, m_eact, m_en;
  logic [4:0]  m_x, m_y;
  logic [2:0]  m_type, m_etype;
  int          spawn_edge_cyc = 0;
  int          stalls = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] fold(input logic [4:0] v);
    int t;
    t = int'(v);
    if (t > GM) t = t - (GM + 1);
    return 5'(t);
  endfunction

  function automatic logic [15:0] next_lfsr(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_phase = M_IDLE; m_cnt = 0;
    m_set = 1'b0; m_ev = 1'b0; m_eact = 1'b0; m_en = 1'b0;
    m_x = 5'd0; m_y = 5'd0; m_type = 3'd0; m_etype = 3'd0;
  endtask

  task automatic model_edge();
    logic [4:0] sx, sy;
    logic [2:0] sk;
    sx = fold(m_lfsr[6:2]);
    sy = fold(m_lfsr[11:7]);
    sk = 3'(m_lfsr[1:0]) + 3'd1;
    m_lfsr = next_lfsr(m_lfsr);
    m_en = game_en;
    m_ev = 1'b0;
    if (!game_en) begin
      m_phase = M_IDLE; m_cnt = 0; m_set = 1'b0; m_eact = 1'b0;
    end else begin
      case (m_phase)
        M_IDLE: begin m_phase = M_WAIT; m_cnt = 0; end
        M_WAIT: if (tick) begin
          if (m_cnt == SD - 1) begin
            m_phase = M_SPAWN; m_cnt = 0; spawn_edge_cyc = cyc; stalls = 0;
          end else m_cnt++;
        end
        M_SPAWN: begin
          if (sx == tank_xpos && sy == tank_ypos) stalls++;
          else begin
            m_x = sx; m_y = sy; m_type = sk; m_set = 1'b1; m_cnt = 0; m_phase = M_SHOW;
          end
        end
        M_SHOW: begin
          if (tank_xpos == m_x && tank_ypos == m_y) begin
            m_set = 1'b0; m_ev = 1'b1; m_etype = m_type; m_eact = 1'b1; m_cnt = 0;
            m_phase = M_EFFECT;
          end else if (tick) begin
            if (m_cnt == ST - 1) begin
              m_set = 1'b0; m_cnt = 0; m_phase = M_WAIT;
            end else m_cnt++;
          end
        end
        default: if (tick) begin
          if (m_cnt == ET - 1) begin
            m_eact = 1'b0; m_cnt = 0; m_phase = M_WAIT;
          end else m_cnt++;
        end
      endcase
    end
  endtask

  task automatic check_all();
    chk("set_require", 32'(set_require), 32'(m_set));
    chk("enable_reward", 32'(enable_reward), 32'(m_en));
    chk("random_xpos", 32'(random_xpos), 32'(m_x));
    chk("random_ypos", 32'(random_ypos), 32'(m_y));
    chk("reward_type", 32'(reward_type), 32'(m_type));
    chk("effect_valid", 32'(effect_valid), 32'(m_ev));
    chk("effect_type", 32'(effect_type), 32'(m_etype));
    chk("effect_active", 32'(effect_active), 32'(m_eact));
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic drive_auto();
    tick_cnt++;
    tick = (tick_cnt % period == 0);
    case (tank_mode)
      TANK_AWAY: begin tank_xpos = 5'd31; tank_ypos = 5'd31; end
      TANK_CHASE: begin
        if (m_phase == M_SHOW) begin tank_xpos = m_x; tank_ypos = m_y; end
        else begin tank_xpos = 5'd31; tank_ypos = 5'd31; end
      end
      default: ;
    endcase
    clk_cycle();
  endtask

  initial begin
    rst_n = 1'b0; game_en = 1'b1; tick = 1'b0; tank_xpos = 5'd0; tank_ypos = 5'd0;
    model_reset();
    #2 check_all();
    #10 check_all();
    rst_n = 1'b1;

    // spawn after SPAWN_DELAY ticks with the tank parked at (0,0)
    for (int k = 0; k < 60 && !set_require; k++) drive_auto();
    chk("t1_spawned", 32'(set_require), 32'd1);
    chk("t1_rise_latency", 32'(cyc - spawn_edge_cyc), 32'(1 + stalls));
    chk("t1_x_range", 32'(random_xpos <= 5'd23), 32'd1);
    chk("t1_y_range", 32'(random_ypos <= 5'd23), 32'd1);
    chk("t1_type_range", 32'(reward_type >= 3'd1 && reward_type <= 3'd4), 32'd1);

    // pickup, then the effect lasts EFFECT_TIME ticks
    tank_mode = TANK_CHASE;
    for (int k = 0; k < 100 && !effect_valid; k++) drive_auto();
    chk("t2_pickup_pulse", 32'(effect_valid), 32'd1);
    chk("t2_set_cleared", 32'(set_require), 32'd0);
    chk("t2_effect_type", 32'(effect_type), 32'(m_type));
    tank_mode = TANK_AWAY;
    ticks = 0; pulses = 0;
    for (int k = 0; k < 100 && effect_active; k++) begin
      drive_auto();
      if (tick) ticks++;
      if (effect_valid) pulses++;
    end
    chk("t2_effect_ticks", 32'(ticks), 32'(ET));
    chk("t2_single_pulse", 32'(pulses), 32'd0);

    // expiry after SHOW_TIME ticks, then respawn after SPAWN_DELAY ticks
    for (int k = 0; k < 100 && !set_require; k++) drive_auto();
    chk("t3_shown", 32'(set_require), 32'd1);
    ticks = 0; pulses = 0;
    for (int k = 0; k < 200 && set_require; k++) begin
      drive_auto();
      if (tick) ticks++;
      if (effect_valid) pulses++;
    end
    chk("t3_show_ticks", 32'(ticks), 32'(ST));
    chk("t3_no_effect", 32'(pulses), 32'd0);
    ticks = 0;
    for (int k = 0; k < 100 && !set_require; k++) begin
      drive_auto();
      if (tick) ticks++;
    end
    chk("t3_wait_ticks", 32'(ticks), 32'(SD));

    // pickup coincides with the final SHOW tick
    for (int i = 0; i < ST - 1; i++) begin
      tick = 1'b1; clk_cycle();
      tick = 1'b0; clk_cycle();
    end
    chk("t4_still_shown", 32'(set_require), 32'd1);
    tick = 1'b1; tank_xpos = m_x; tank_ypos = m_y;
    clk_cycle();
    chk("t4_pickup_wins", 32'(effect_valid), 32'd1);
    chk("t4_active", 32'(effect_active), 32'd1);
    tick = 1'b0;
    for (int k = 0; k < 100 && effect_active; k++) drive_auto();

    // sampled cell forced onto the tank cell
    for (int k = 0; k < 100 && m_phase != M_SPAWN; k++) drive_auto();
    tank_xpos = fold(m_lfsr[6:2]); tank_ypos = fold(m_lfsr[11:7]); tick = 1'b0;
    clk_cycle();
    chk("t5_stays_spawn", 32'(set_require), 32'd0);
    for (int k = 0; k < 20 && !set_require; k++) clk_cycle();
    chk("t5_spawned", 32'(set_require), 32'd1);
    chk("t5_cell_differs", 32'(random_xpos != tank_xpos || random_ypos != tank_ypos), 32'd1);

    // game_en drop in SHOW and in EFFECT, then reset mid-EFFECT
    game_en = 1'b0; clk_cycle();
    chk("t6_show_drop_set", 32'(set_require), 32'd0);
    chk("t6_show_drop_en", 32'(enable_reward), 32'd0);
    game_en = 1'b1; tank_mode = TANK_CHASE;
    for (int k = 0; k < 150 && !effect_valid; k++) drive_auto();
    chk("t6_pickup", 32'(effect_valid), 32'd1);
    tick = 1'b0; tank_xpos = 5'd31; tank_ypos = 5'd31;
    clk_cycle();
    game_en = 1'b0; clk_cycle();
    chk("t6_effect_drop_active", 32'(effect_active), 32'd0);
    chk("t6_etype_nonzero", 32'(effect_type != 3'd0), 32'd1);
    game_en = 1'b1;
    for (int k = 0; k < 150 && !effect_valid; k++) drive_auto();
    tank_mode = TANK_AWAY; tick = 1'b0; tank_xpos = 5'd31; tank_ypos = 5'd31;
    clk_cycle();
    chk("t6_in_effect", 32'(effect_active), 32'd1);
    rst_n = 1'b0; model_reset();
    #1;
    check_all();
    chk("t6_rst_etype", 32'(effect_type), 32'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) drive_auto();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      game_en = ($urandom_range(0, 39) != 0);
      tick = ($urandom_range(0, 2) == 0);
      if (m_phase == M_SHOW && $urandom_range(0, 3) == 0) begin
        tank_xpos = m_x; tank_ypos = m_y;
      end else begin
        tank_xpos = 5'($urandom_range(0, 31));
        tank_ypos = 5'($urandom_range(0, 31));
      end
      clk_cycle();
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; model_reset();
        #1 check_all();
        #1 rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
